// File: rtl/reset_sequencer.sv
// Releases STAGES downstream reset domains in index order after the POR reset clears.
// Latency: stage 0 releases HOLD_CYCLES+3 edges after in_reset_n is first sampled high.
// No backpressure: any abort, ready loss or timeout re-asserts every stage reset at once.
// Optional macro RESET_SEQ_RETRY_EN: a timeout re-sequences up to MAX_RETRIES times before faulting.
module reset_sequencer #(
  parameter int STAGES         = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int DWELL_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRIES    = 3
) (
  input  logic              clock_reg,
  input  logic              reset_n,
  input  logic              in_reset_n,
  input  logic              in_reset_req,
  input  logic [STAGES-1:0] stage_ready,
  output logic [STAGES-1:0] stage_reset_n,
  output logic              all_released,
  output logic              busy,
  output logic              fault,
  output logic [2:0]        fault_stage
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int DW = $clog2(DWELL_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  // Elaboration-time guard on the legal parameter ranges.
  if (STAGES < 1 || STAGES > 8 || HOLD_CYCLES < 1 || DWELL_CYCLES < 1 ||
      TIMEOUT_CYCLES <= DWELL_CYCLES || MAX_RETRIES < 0) begin : g_param_check
    $error("reset_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_WAIT,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        idx, idx_nxt;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic [DW-1:0]     dwell_cnt, dwell_nxt;
  logic [TW-1:0]     tmo_cnt, tmo_nxt;
  logic [STAGES-1:0] rst_nxt;
  logic              all_nxt, busy_nxt, fault_nxt;
  logic [2:0]        fs_nxt;

  logic              in_meta, in_sync;
  logic [STAGES-1:0] rdy_meta, rdy_sync;
  logic              rdy_sel;

`ifdef RESET_SEQ_RETRY_EN
  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
  logic [RW-1:0] retry_cnt, retry_nxt;

  // Retry counter register, present only when retries are enabled.
  always_ff @(posedge clock_reg or negedge reset_n) begin
    if (!reset_n) retry_cnt <= '0;
    else          retry_cnt <= retry_nxt;
  end
`endif

  // Two-flop synchronizers for the POR level and the per-stage ready inputs.
  always_ff @(posedge clock_reg or negedge reset_n) begin
    if (!reset_n) begin
      in_meta  <= 1'b0;
      in_sync  <= 1'b0;
      rdy_meta <= '0;
      rdy_sync <= '0;
    end else begin
      in_meta  <= in_reset_n;
      in_sync  <= in_meta;
      rdy_meta <= stage_ready;
      rdy_sync <= rdy_meta;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock_reg or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_HOLD;
      idx           <= '0;
      hold_cnt      <= '0;
      dwell_cnt     <= '0;
      tmo_cnt       <= '0;
      stage_reset_n <= '0;
      all_released  <= 1'b0;
      busy          <= 1'b1;
      fault         <= 1'b0;
      fault_stage   <= '0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      hold_cnt      <= hold_nxt;
      dwell_cnt     <= dwell_nxt;
      tmo_cnt       <= tmo_nxt;
      stage_reset_n <= rst_nxt;
      all_released  <= all_nxt;
      busy          <= busy_nxt;
      fault         <= fault_nxt;
      fault_stage   <= fs_nxt;
    end
  end

  // Next-state and next-output logic; the global abort overrides every state.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    hold_nxt  = hold_cnt;
    dwell_nxt = dwell_cnt;
    tmo_nxt   = tmo_cnt;
    rst_nxt   = stage_reset_n;
    all_nxt   = all_released;
    busy_nxt  = busy;
    fault_nxt = fault;
    fs_nxt    = fault_stage;
`ifdef RESET_SEQ_RETRY_EN
    retry_nxt = retry_cnt;
`endif
    // Only the stage currently being brought up is watched while waiting.
    rdy_sel = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (idx == 3'(k)) rdy_sel = rdy_sync[k];
    end

    if (in_reset_req || !in_sync) begin
      state_nxt = ST_HOLD;
      hold_nxt  = '0;
      rst_nxt   = '0;
      all_nxt   = 1'b0;
      busy_nxt  = 1'b1;
      fault_nxt = 1'b0;
`ifdef RESET_SEQ_RETRY_EN
      retry_nxt = '0;
`endif
    end else begin
      case (state)
        ST_HOLD: begin
          rst_nxt  = '0;
          busy_nxt = 1'b1;
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            state_nxt = ST_RELEASE;
            idx_nxt   = '0;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + HW'(1);
          end
        end
        ST_RELEASE: begin
          for (int k = 0; k < STAGES; k++) begin
            if (idx == 3'(k)) rst_nxt[k] = 1'b1;
          end
          dwell_nxt = '0;
          tmo_nxt   = '0;
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          tmo_nxt   = tmo_cnt + TW'(1);
          dwell_nxt = rdy_sel ? dwell_cnt + DW'(1) : '0;
          if (rdy_sel && dwell_cnt == DW'(DWELL_CYCLES - 1)) begin
            if (idx == 3'(STAGES - 1)) begin
              state_nxt = ST_RUN;
              all_nxt   = 1'b1;
              busy_nxt  = 1'b0;
`ifdef RESET_SEQ_RETRY_EN
              retry_nxt = '0;
`endif
            end else begin
              idx_nxt   = idx + 3'd1;
              state_nxt = ST_RELEASE;
            end
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            rst_nxt = '0;
`ifdef RESET_SEQ_RETRY_EN
            if (retry_cnt == RW'(MAX_RETRIES)) begin
              state_nxt = ST_FAULT;
              fault_nxt = 1'b1;
              fs_nxt    = idx;
              busy_nxt  = 1'b0;
            end else begin
              state_nxt = ST_HOLD;
              hold_nxt  = '0;
              retry_nxt = retry_cnt + RW'(1);
            end
`else
            state_nxt = ST_FAULT;
            fault_nxt = 1'b1;
            fs_nxt    = idx;
            busy_nxt  = 1'b0;
`endif
          end
        end
        ST_RUN: begin
          if (!(&rdy_sync)) begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
            rst_nxt   = '0;
            all_nxt   = 1'b0;
            busy_nxt  = 1'b1;
          end
        end
        ST_FAULT: begin
          rst_nxt  = '0;
          busy_nxt = 1'b0;
        end
        default: begin
          state_nxt = ST_HOLD;
          rst_nxt   = '0;
          busy_nxt  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a responder raises each stage_ready a chosen delay after release.
// Expected output waveforms come from an arithmetic schedule of release/run/fault edges.
// Build with RESET_SEQ_RETRY_EN defined to exercise the retry path instead of the direct fault.
module tb_reset_sequencer;

  localparam int S     = 4;
  localparam int HOLD  = 16;
  localparam int DWELL = 8;
  localparam int TMO   = 64;
  localparam int MAXR  = 2;

  logic         clock_reg = 1'b0;
  logic         reset_n;
  logic         in_reset_n;
  logic         in_reset_req;
  logic [S-1:0] stage_ready;
  logic [S-1:0] stage_reset_n;
  logic         all_released;
  logic         busy;
  logic         fault;
  logic [2:0]   fault_stage;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int dly[S];
  int glt[S];
  int age[S];
  bit drop[S];
  int rise0;
  int rise2;

  always #5 clock_reg = ~clock_reg;

  reset_sequencer #(
    .STAGES(S), .HOLD_CYCLES(HOLD), .DWELL_CYCLES(DWELL),
    .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)
  ) dut (
    .clock_reg(clock_reg), .reset_n(reset_n), .in_reset_n(in_reset_n),
    .in_reset_req(in_reset_req), .stage_ready(stage_ready),
    .stage_reset_n(stage_reset_n), .all_released(all_released), .busy(busy),
    .fault(fault), .fault_stage(fault_stage)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s cyc=%0d: observed %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: advance past the edge, then let each stage respond to its reset.
  task automatic step();
    @(posedge clock_reg);
    #1;
    cyc++;
    for (int k = 0; k < S; k++) begin
      if (!stage_reset_n[k]) begin
        age[k] = -1;
        drop[k] = 1'b0;
        stage_ready[k] = 1'b0;
      end else begin
        age[k]++;
        stage_ready[k] = !drop[k] && age[k] >= dly[k] &&
                         !(glt[k] != 0 && age[k] == dly[k] + glt[k]);
      end
    end
  endtask

  // Offset after release where ready goes high and stays high.
  function automatic int start_of(input int k);
    if (glt[k] > 0 && glt[k] < DWELL) return dly[k] + glt[k] + 1;
    return dly[k];
  endfunction

  // b: edge after which the DUT sits in HOLD with a cleared hold count.
  task automatic check_seq(input int b, input int limit);
    int rel[S];
    int run_e, flt_e, flt_s, end_e, st, done;
    logic [S-1:0] er;
    for (int k = 0; k < S; k++) rel[k] = 32'h7fffffff;
    run_e = -1;
    flt_e = -1;
    flt_s = 0;
    rel[0] = b + HOLD + 1;
    for (int k = 0; k < S; k++) begin
      st = start_of(k);
      if (st + 2 + DWELL > TMO) begin
        flt_e = rel[k] + TMO;
        flt_s = k;
        break;
      end
      done = rel[k] + st + 2 + DWELL;
      if (k == S - 1) run_e = done;
      else rel[k+1] = done + 1;
    end
    end_e = ((run_e >= 0) ? run_e : flt_e) + 4;
    if (end_e > b + limit) end_e = b + limit;
    rise0 = -1;
    rise2 = -1;
    while (cyc < b) step();
    while (1) begin
      for (int k = 0; k < S; k++) er[k] = (cyc >= rel[k]) && !(flt_e >= 0 && cyc >= flt_e);
      chk("stage_reset_n", stage_reset_n, er);
      chk("all_released", all_released, run_e >= 0 && cyc >= run_e);
      chk("busy", busy, !((run_e >= 0 && cyc >= run_e) || (flt_e >= 0 && cyc >= flt_e)));
      chk("fault", fault, flt_e >= 0 && cyc >= flt_e);
      if (flt_e >= 0 && cyc >= flt_e) chk("fault_stage", fault_stage, flt_s);
      if (rise0 < 0 && stage_reset_n[0]) rise0 = cyc;
      if (rise2 < 0 && stage_reset_n[2]) rise2 = cyc;
      if (cyc >= end_e) break;
      step();
    end
  endtask

  task automatic pulse_req(output int b);
    in_reset_req = 1'b1;
    step();
    in_reset_req = 1'b0;
    b = cyc;
  endtask

  initial begin
    int c, b, clean2, attempts;
    logic prev;
    reset_n      = 1'b0;
    in_reset_n   = 1'b0;
    in_reset_req = 1'b0;
    stage_ready  = '0;
    for (int k = 0; k < S; k++) begin
      dly[k] = 5; glt[k] = 0; age[k] = -1; drop[k] = 1'b0;
    end
    #12;
    chk("rst_stage_reset_n", stage_reset_n, 0);
    chk("rst_all_released", all_released, 0);
    chk("rst_busy", busy, 1);
    chk("rst_fault", fault, 0);
    chk("rst_fault_stage", fault_stage, 0);

    step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("por_low_stage_reset_n", stage_reset_n, 0);
    chk("por_low_busy", busy, 1);

    // Bring-up with every stage ready 5 cycles after release.
    in_reset_n = 1'b1;
    c = cyc;
    check_seq(c + 2, 200);
    chk("bringup_latency", rise0 - c, 19);
    clean2 = rise2 - (c + 2);

    // Ready loss while running re-sequences from HOLD.
    repeat (3) step();
    drop[3] = 1'b1;
    stage_ready[3] = 1'b0;
    c = cyc;
    check_seq(c + 3, 200);

    // One-cycle dwell glitch on stage 1 after 5 good cycles.
    glt[1] = 5;
    pulse_req(b);
    check_seq(b, 200);
    chk("glitch_delay", (rise2 - b) - clean2, 6);
    glt[1] = 0;

`ifndef RESET_SEQ_RETRY_EN
    // Stage 2 never reports ready: direct fault.
    dly[2] = 1000;
    pulse_req(b);
    check_seq(b, 400);
    dly[2] = 5;
`else
    // Stage 0 never reports ready: retries, then fault.
    dly[0] = 1000;
    pulse_req(b);
    attempts = 0;
    prev = 1'b0;
    for (int i = 0; i < 600 && !fault; i++) begin
      step();
      if (stage_reset_n[0] && !prev) attempts++;
      prev = stage_reset_n[0];
    end
    chk("retry_attempts", attempts, MAXR + 1);
    chk("retry_fault", fault, 1);
    chk("retry_fault_stage", fault_stage, 0);
    chk("retry_stage_reset_n", stage_reset_n, 0);
    dly[0] = 5;
`endif

    // Recovery out of FAULT by a request pulse.
    pulse_req(b);
    check_seq(b, 200);

    // POR level dropping mid-WAIT aborts, then the sequence restarts.
    for (int k = 0; k < S; k++) dly[k] = $urandom_range(0, 20);
    pulse_req(b);
    check_seq(b, HOLD + 1 + 6);
    in_reset_n = 1'b0;
    repeat (3) step();
    chk("abort_stage_reset_n", stage_reset_n, 0);
    chk("abort_busy", busy, 1);
    chk("abort_fault", fault, 0);
    chk("abort_all_released", all_released, 0);
    in_reset_n = 1'b1;
    c = cyc;
    check_seq(c + 2, 300);

    // Randomized ready delays and dwell glitches.
    repeat (6) begin
      for (int k = 0; k < S; k++) begin
        dly[k] = $urandom_range(0, 20);
        glt[k] = ($urandom_range(0, 1) != 0) ? $urandom_range(1, DWELL - 1) : 0;
      end
      pulse_req(b);
      check_seq(b, 300);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
